// File: rtl/data_router_pkg.sv
// Encodings shared by the input-register-array sequencer and the register array.
// Both sides import this package so command codes can never drift apart.
package data_router_pkg;

  typedef enum logic [1:0] {
    CMD_BUFIN = 2'b00,
    CMD_SHIFT = 2'b01,
    CMD_FIFOI = 2'b10,
    CMD_HOLD  = 2'b11
  } ra_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  // Row reuse through the FIFO only works when windows overlap, i.e. STRIDE < KSIZE.
  function automatic bit stride_legal(int ksize, int stride);
    return (ksize >= 1) && (ksize <= 7) && ((stride == 1) || (stride == 2)) && (stride < ksize);
  endfunction

endpackage

// File: rtl/reg_array_seq_if.sv
// Control and command bundle between the tile controller, the sequencer and the register array.
// master = the sequencer, slave = the side that starts tiles and consumes commands.
interface reg_array_seq_if #(
  parameter int ADDRW = 8,
  parameter int ORW   = 8
);
  logic             start;
  logic [ORW-1:0]   cfg_orows;
  logic             pe_stall;
  logic [1:0]       reg_array_cmd;
  logic [ADDRW-1:0] buf_rd_addr;
  logic             fifo_pop;
  logic             fifo_push;
  logic             pe_valid;
  logic [2:0]       pe_kx;
  logic [2:0]       pe_ky;
  logic             row_done;
  logic             tile_done;
  logic             busy;

  modport master (
    input  start, cfg_orows, pe_stall,
    output reg_array_cmd, buf_rd_addr, fifo_pop, fifo_push,
           pe_valid, pe_kx, pe_ky, row_done, tile_done, busy
  );

  modport slave (
    output start, cfg_orows, pe_stall,
    input  reg_array_cmd, buf_rd_addr, fifo_pop, fifo_push,
           pe_valid, pe_kx, pe_ky, row_done, tile_done, busy
  );
endinterface

// File: rtl/reg_array_seq.sv
// Walks the KSIZE x KSIZE window over a tile of output rows, issuing one register-array
// command per unstalled cycle; PE-side tags trail the issue by one cycle.
module reg_array_seq
  import data_router_pkg::*;
#(
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int ADDRW  = 8,
  parameter int ORW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_array_seq_if.master  bus
);

  generate
    if (!stride_legal(KSIZE, STRIDE)) begin : g_bad_cfg
      $error("reg_array_seq: illegal KSIZE/STRIDE combination");
    end
  endgenerate

  localparam logic [2:0] K_LAST  = 3'(KSIZE - 1);
  localparam logic [2:0] REUSE_N = 3'(KSIZE - STRIDE);
  localparam logic [2:0] STR     = 3'(STRIDE);

  seq_state_e     state_reg, state_next;
  logic [2:0]     kx_reg, ky_reg;
  logic [ORW-1:0] oy_reg, orows_reg;
  logic           pe_valid_reg, row_done_reg, tile_done_reg, busy_reg;
  logic [2:0]     pe_kx_reg, pe_ky_reg;

  ra_cmd_e          cmd_next;
  logic [ADDRW-1:0] addr_next;
  logic             pop_next, push_next, issue;
  logic             kx_last, ky_last, oy_last, oy_more, accept;
  logic [ORW:0]     oy_inc;
  logic [31:0]      addr_full;

  assign kx_last   = (kx_reg == K_LAST);
  assign ky_last   = (ky_reg == K_LAST);
  assign oy_inc    = {1'b0, oy_reg} + (ORW+1)'(1);
  assign oy_last   = (oy_inc == {1'b0, orows_reg});
  assign oy_more   = (oy_inc <  {1'b0, orows_reg});
  assign addr_full = 32'(oy_reg) * 32'(STRIDE) + 32'(ky_reg);
  assign accept    = (state_reg == ST_IDLE) && bus.start;

  always_comb begin
    state_next = state_reg;
    cmd_next   = CMD_HOLD;
    addr_next  = '0;
    pop_next   = 1'b0;
    push_next  = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start)
          state_next = (bus.cfg_orows != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (!bus.pe_stall) begin
          issue = 1'b1;
          if (kx_reg != 3'd0) begin
            cmd_next = CMD_SHIFT;
          end else if ((oy_reg != '0) && (ky_reg < REUSE_N)) begin
            // Rows already seen by the previous output row come back from the FIFO.
            cmd_next = CMD_FIFOI;
            pop_next = 1'b1;
          end else begin
            cmd_next  = CMD_BUFIN;
            addr_next = addr_full[ADDRW-1:0];
          end
          push_next = (kx_reg == 3'd0) && (ky_reg >= STR) && oy_more;
          if (kx_last && ky_last && oy_last)
            state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      kx_reg        <= '0;
      ky_reg        <= '0;
      oy_reg        <= '0;
      orows_reg     <= '0;
      pe_valid_reg  <= 1'b0;
      pe_kx_reg     <= '0;
      pe_ky_reg     <= '0;
      row_done_reg  <= 1'b0;
      tile_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        orows_reg <= bus.cfg_orows;
        kx_reg    <= '0;
        ky_reg    <= '0;
        oy_reg    <= '0;
      end else if (issue) begin
        if (kx_last) begin
          kx_reg <= '0;
          if (ky_last) begin
            ky_reg <= '0;
            oy_reg <= oy_inc[ORW-1:0];
          end else begin
            ky_reg <= ky_reg + 3'd1;
          end
        end else begin
          kx_reg <= kx_reg + 3'd1;
        end
      end
      pe_valid_reg <= issue;
      if (issue) begin
        pe_kx_reg <= kx_reg;
        pe_ky_reg <= ky_reg;
      end
      row_done_reg  <= issue && kx_last && ky_last;
      // An empty tile still reports completion one cycle after the start.
      tile_done_reg <= (issue && kx_last && ky_last && oy_last) ||
                       (accept && (bus.cfg_orows == '0));
      busy_reg      <= (state_next != ST_IDLE);
    end
  end

  assign bus.reg_array_cmd = cmd_next;
  assign bus.buf_rd_addr   = addr_next;
  assign bus.fifo_pop      = pop_next;
  assign bus.fifo_push     = push_next;
  assign bus.pe_valid      = pe_valid_reg;
  assign bus.pe_kx         = pe_kx_reg;
  assign bus.pe_ky         = pe_ky_reg;
  assign bus.row_done      = row_done_reg;
  assign bus.tile_done     = tile_done_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_reg_array_seq.sv
// Bench for reg_array_seq: three instances (K3/S1, K3/S2, K5/S1) driven from a scenario table
// plus random tiles, checked cycle by cycle against a loop-generated issue list and a row-FIFO model.
module tb_reg_array_seq;
  import data_router_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       i_start [3];
  logic [7:0] i_orows [3];
  logic       i_stall [3];
  logic [1:0] o_cmd   [3];
  logic [7:0] o_addr  [3];
  logic       o_pop [3], o_push [3], o_valid [3], o_rdone [3], o_tdone [3], o_busy [3];
  logic [2:0] o_kx [3], o_ky [3];

  reg_array_seq_if #(.ADDRW(8), .ORW(8)) bus [3] ();

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      assign bus[gi].start     = i_start[gi];
      assign bus[gi].cfg_orows = i_orows[gi];
      assign bus[gi].pe_stall  = i_stall[gi];
      assign o_cmd[gi]   = bus[gi].reg_array_cmd;
      assign o_addr[gi]  = bus[gi].buf_rd_addr;
      assign o_pop[gi]   = bus[gi].fifo_pop;
      assign o_push[gi]  = bus[gi].fifo_push;
      assign o_valid[gi] = bus[gi].pe_valid;
      assign o_kx[gi]    = bus[gi].pe_kx;
      assign o_ky[gi]    = bus[gi].pe_ky;
      assign o_rdone[gi] = bus[gi].row_done;
      assign o_tdone[gi] = bus[gi].tile_done;
      assign o_busy[gi]  = bus[gi].busy;
      reg_array_seq #(.KSIZE(gi == 2 ? 5 : 3), .STRIDE(gi == 1 ? 2 : 1), .ADDRW(8), .ORW(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  function automatic int kof(int u); return (u == 2) ? 5 : 3; endfunction
  function automatic int sof(int u); return (u == 1) ? 2 : 1; endfunction

  typedef struct {int kx; int ky; int oy; int cmd; int addr; int pop; int push;} iss_t;
  iss_t iq[$];
  int   fifo_q[$];

  // Reference issue list straight from the window-walk rules.
  task automatic build(int u, int orows);
    int k = kof(u);
    int s = sof(u);
    iss_t r;
    iq.delete();
    for (int oy = 0; oy < orows; oy++)
      for (int ky = 0; ky < k; ky++)
        for (int kx = 0; kx < k; kx++) begin
          r.kx = kx; r.ky = ky; r.oy = oy;
          r.addr = 0; r.pop = 0;
          if (kx > 0) r.cmd = 1;
          else if (oy > 0 && ky < k - s) begin r.cmd = 2; r.pop = 1; end
          else begin r.cmd = 0; r.addr = (oy * s + ky) % 256; end
          r.push = (kx == 0 && ky >= s && oy < orows - 1) ? 1 : 0;
          iq.push_back(r);
        end
  endtask

  task automatic chk_reset_vals(int u, string tag);
    chk({tag, "_cmd"}, o_cmd[u], 3);
    chk({tag, "_addr"}, o_addr[u], 0);
    chk({tag, "_pop"}, o_pop[u], 0);
    chk({tag, "_push"}, o_push[u], 0);
    chk({tag, "_valid"}, o_valid[u], 0);
    chk({tag, "_kx"}, o_kx[u], 0);
    chk({tag, "_ky"}, o_ky[u], 0);
    chk({tag, "_rdone"}, o_rdone[u], 0);
    chk({tag, "_tdone"}, o_tdone[u], 0);
    chk({tag, "_busy"}, o_busy[u], 0);
  endtask

  typedef struct {
    int unit; int orows; int stall_at; int stall_len; int poke; int abort_at;
    int exp_done; int exp_valids; int exp_rdone; string exp_cmds; string exp_addrs;
  } scen_t;

  task automatic run_tile(scen_t s);
    int u = s.unit;
    int n, idx, prev_idx, done_c, valids, rdones, stall_rem, popped, loaded;
    bit prev_iss, finished, stall, exp_iss, in_done;
    iss_t rec, prev_rec;
    string cmd_log, addr_log;
    build(u, s.orows);
    n = iq.size();
    fifo_q.delete();
    cmd_log = ""; addr_log = "";
    idx = 0; prev_idx = -1; done_c = -1; valids = 0; rdones = 0;
    prev_iss = 0; finished = 0; stall_rem = s.stall_len;
    prev_rec = '{0, 0, 0, 3, 0, 0, 0};

    @(posedge clk); #1;
    i_orows[u] = 8'(s.orows); i_start[u] = 1'b1; i_stall[u] = 1'b0;
    @(negedge clk);
    chk("start_cycle_cmd", o_cmd[u], 3);
    chk("start_cycle_busy", o_busy[u], 0);

    for (int c = 1; c <= 400 && !finished; c++) begin
      @(posedge clk); #1;
      i_start[u] = 1'b0;
      stall = (idx < n) && (idx == s.stall_at) && (stall_rem > 0);
      if (stall) stall_rem--;
      i_stall[u] = stall;
      in_done = (n > 0 && prev_iss && prev_idx == n - 1) || (n == 0 && c == 1);
      if (s.poke != 0 && ((idx == 3 && !in_done) || in_done)) begin
        i_start[u] = 1'b1;
        i_orows[u] = 8'd5;
      end
      if (idx == s.abort_at && idx < n) begin
        rst_n = 1'b0;
        #1;
        chk_reset_vals(u, "abort");
        i_start[u] = 1'b0; i_stall[u] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("tile unit=%0d orows=%0d aborted at issue %0d", u, s.orows, idx);
        return;
      end
      @(negedge clk);
      exp_iss = (idx < n) && !stall;
      if (exp_iss) rec = iq[idx];
      else rec = '{0, 0, 0, 3, 0, 0, 0};
      chk("cmd", o_cmd[u], rec.cmd);
      chk("pop", o_pop[u], rec.pop);
      chk("push", o_push[u], rec.push);
      if (rec.cmd == 0 || rec.cmd == 3) chk("addr", o_addr[u], rec.addr);
      chk("pe_valid", o_valid[u], prev_iss);
      if (prev_iss) begin
        chk("pe_kx", o_kx[u], prev_rec.kx);
        chk("pe_ky", o_ky[u], prev_rec.ky);
      end
      chk("row_done", o_rdone[u],
          (prev_iss && prev_rec.kx == kof(u) - 1 && prev_rec.ky == kof(u) - 1) ? 1 : 0);
      chk("tile_done", o_tdone[u], in_done);
      chk("busy", o_busy[u], 1);
      if (exp_iss) begin
        case (o_cmd[u])
          2'd0: cmd_log = {cmd_log, "B"};
          2'd1: cmd_log = {cmd_log, "S"};
          2'd2: cmd_log = {cmd_log, "F"};
          default: cmd_log = {cmd_log, "H"};
        endcase
        if (o_cmd[u] == 2'd0) addr_log = {addr_log, $sformatf("%0d,", o_addr[u])};
        // Row FIFO model: what comes out must be exactly the row this window position needs.
        popped = -1;
        if (o_pop[u]) begin
          if (fifo_q.size() == 0) chk("fifo_underflow", 1, 0);
          else begin
            popped = fifo_q.pop_front();
            chk("fifo_row", popped, rec.oy * sof(u) + rec.ky);
          end
        end
        loaded = (o_cmd[u] == 2'd0) ? int'(o_addr[u]) : popped;
        if (o_push[u]) fifo_q.push_back(loaded);
        if (fifo_q.size() > kof(u) - sof(u)) chk("fifo_depth", fifo_q.size(), kof(u) - sof(u));
      end
      valids += int'(o_valid[u]);
      rdones += int'(o_rdone[u]);
      if (o_tdone[u] && done_c < 0) done_c = c;
      prev_iss = exp_iss;
      if (exp_iss) begin
        prev_rec = rec; prev_idx = idx; idx++;
      end
      if (in_done) finished = 1;
    end
    if (!finished) chk("tile_timeout", 0, 1);

    @(posedge clk); #1;
    i_start[u] = 1'b0; i_stall[u] = 1'b0;
    @(negedge clk);
    chk("after_busy", o_busy[u], 0);
    chk("after_cmd", o_cmd[u], 3);
    chk("after_valid", o_valid[u], 0);
    chk("done_cycle", done_c, s.exp_done);
    chk("valid_count", valids, s.exp_valids);
    chk("row_done_count", rdones, s.exp_rdone);
    if (s.exp_cmds != "") chk_str("cmd_stream", cmd_log, s.exp_cmds);
    if (s.exp_addrs != "") chk_str("bufin_addrs", addr_log, s.exp_addrs);
    $display("tile unit=%0d K=%0d S=%0d orows=%0d stall=%0d@%0d done_cycle=%0d valids=%0d cmds=%s",
             u, kof(u), sof(u), s.orows, s.stall_len, s.stall_at, done_c, valids, cmd_log);
  endtask

  initial begin
    scen_t tbl [8];
    scen_t rs;
    tbl[0] = '{0, 2, -1, 0, 0, -1, 19, 18, 2, "BSSBSSBSSFSSFSSBSS", "0,1,2,3,"};
    tbl[1] = '{1, 2, -1, 0, 0, -1, 19, 18, 2, "BSSBSSBSSFSSBSSBSS", "0,1,2,3,4,"};
    tbl[2] = '{0, 2,  5, 3, 0, -1, 22, 18, 2, "BSSBSSBSSFSSFSSBSS", "0,1,2,3,"};
    tbl[3] = '{0, 0, -1, 0, 0, -1,  1,  0, 0, "", ""};
    tbl[4] = '{0, 2, -1, 0, 1, -1, 19, 18, 2, "BSSBSSBSSFSSFSSBSS", "0,1,2,3,"};
    tbl[5] = '{0, 2, -1, 0, 0,  7,  0,  0, 0, "", ""};
    tbl[6] = '{0, 2, -1, 0, 0, -1, 19, 18, 2, "BSSBSSBSSFSSFSSBSS", "0,1,2,3,"};
    tbl[7] = '{2, 3, -1, 0, 0, -1, 76, 75, 3, "", ""};

    for (int i = 0; i < 3; i++) begin
      i_start[i] = 1'b0; i_orows[i] = 8'd0; i_stall[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset_vals(i, "reset");
    $display("reset values checked on all units");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_tile(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      int k;
      rs.unit = int'($urandom_range(0, 2));
      rs.orows = int'($urandom_range(1, 3));
      k = kof(rs.unit);
      rs.stall_len = int'($urandom_range(0, 4));
      rs.stall_at = int'($urandom_range(0, rs.orows * k * k - 1));
      rs.poke = 0; rs.abort_at = -1;
      rs.exp_done = rs.orows * k * k + 1 + rs.stall_len;
      rs.exp_valids = rs.orows * k * k;
      rs.exp_rdone = rs.orows;
      rs.exp_cmds = ""; rs.exp_addrs = "";
      run_tile(rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_array_seq.md
# reg_array_seq

Command sequencer for the data router's input register array. It walks the KSIZE×KSIZE kernel window over a tile of output rows and issues one register-array command per cycle: load a row from the input buffer, load a reused row from the row FIFO, or shift. It also drives the buffer row address, the FIFO push/pop strobes and the PE-side valid/position tags. It sits directly upstream of the register array and is its only command source.

## Interface
- KSIZE, 3, kernel width/height; 1..7.
- STRIDE, 1, convolution stride; 1 or 2, STRIDE < KSIZE.
- ADDRW, 8, input-buffer row address width.
- ORW, 8, output-row count width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a tile; ignored while busy.
- cfg_orows  in  ORW  output rows in the tile; latched on accepted start.
- pe_stall  in  1  PE backpressure; freezes the sequence.
- reg_array_cmd  out  2  00 BUFIN, 01 SHIFT, 10 FIFOI, 11 HOLD.
- buf_rd_addr  out  ADDRW  input row index; valid when cmd=BUFIN.
- fifo_pop  out  1  pops row FIFO; asserted only with cmd=FIFOI.
- fifo_push  out  1  pushes the row being loaded this cycle into the row FIFO.
- pe_valid  out  1  register-array outputs valid this cycle.
- pe_kx, pe_ky  out  3 each  kernel position of the data under pe_valid.
- row_done  out  1  pulse with the last pe_valid of an output row.
- tile_done  out  1  one-cycle pulse at the end of the tile.
- busy  out  1  high from accepted start until tile_done.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start with cfg_orows≠0.
  - IDLE→DONE on start with cfg_orows=0.
  - RUN→DONE after the last issue.
  - DONE→IDLE unconditionally.
- Counters: kx (fastest), ky, then oy (0..orows−1). Exactly one command is issued per non-stalled RUN cycle.
- Command per issue:
  - kx>0: SHIFT.
  - kx=0, oy>0, ky<KSIZE−STRIDE: FIFOI with fifo_pop=1.
  - Otherwise BUFIN with buf_rd_addr=oy·STRIDE+ky, truncated modulo 2^ADDRW.
- fifo_push=1 on a kx=0 issue (either source) when ky≥STRIDE and oy<orows−1. The FIFO then holds at most KSIZE−STRIDE rows, and push order equals later pop order.
- The input buffer is combinationally read; the row FIFO is show-ahead. Both deliver data in the same cycle as the command.
- In IDLE, DONE or stall: cmd=HOLD, and buf_rd_addr, fifo_pop and fifo_push are all 0.

## Timing
- Reset values: cmd=HOLD (11); all other outputs 0; state IDLE; counters 0.
- All outputs are registered, except that reg_array_cmd, buf_rd_addr, fifo_pop and fifo_push are decoded from current state and counters.
- pe_valid, pe_kx, pe_ky follow the issue by exactly 1 cycle, matching the register array's registered output.
- row_done coincides with the pe_valid of kx=ky=KSIZE−1.
- Stall: pe_stall high in cycle t means no issue in t and pe_valid=0 in t+1. pe_valid already high in t is still consumed. Counters hold.
- Unstalled tile: orows·KSIZE² issue cycles. The first issue is in the cycle after start. tile_done is in the same cycle as the final pe_valid. busy drops the cycle after tile_done.
- With cfg_orows=0, tile_done pulses 1 cycle after start and no commands are issued.
- start during RUN/DONE is ignored. start in the DONE→IDLE cycle is not accepted.
- Reset mid-tile aborts immediately, with no completion pulses.

## Structure
- The shared package data_router_pkg holds:
  - the cmd enum (BUFIN/SHIFT/FIFOI/HOLD);
  - the state enum;
  - the STRIDE legality check function.
- The register array imports the same encodings.
- Single module; counters and decode inline; no sub-module.

## Test plan
- **KSIZE=3, STRIDE=1, orows=2.**
  - Required cmd stream: B S S B S S B S S | F S S F S S B S S.
  - BUFIN addrs 0,1,2,3.
  - Pushes on addr1 and addr2 loads; pops on oy1 ky0 and ky1.
  - tile_done at cycle 19 after start.
- **STRIDE=2, KSIZE=3, orows=2.**
  - Required: oy1 = F S S B S S B S S, with BUFIN addrs 3,4.
  - Single push at oy0 ky2 (addr 2).
- **Stall.** pe_stall high for 3 cycles at issue 5.
  - Command held at HOLD for those cycles.
  - Issue 5 resumes unchanged.
  - pe_valid gap of 3 cycles; tile_done 3 cycles late.
- **Degenerate start.** cfg_orows=0 → tile_done 1 cycle after start, no non-HOLD commands. start pulsed during RUN → ignored, stream unchanged.
- **Reset mid-tile.** Assert rst_n=0 at issue 7 → all outputs return to reset values asynchronously. A fresh start then reproduces the first scenario exactly.
- **Counters.** KSIZE=5, STRIDE=1, orows=3 → 75 pe_valid cycles and 3 row_done pulses. pe_kx/pe_ky sweep row-major.
